// File: rtl/param_bank_ctrl.sv
// param_bank_ctrl: double-buffered parameter bank and frame scheduler.
// Bytes from the frame assembler fill the shadow bank. A complete frame arms
// a swap that lands on the next vsync while the renderer is idle. render_start
// is pulsed on the cycle after swap_pulse.
// Optional feature: define PARAM_CHECKSUM_EN to treat byte NREGS-1 as an 8-bit
// modulo checksum of bytes 0..NREGS-2. This also adds the cks_err_cnt output.
module param_bank_ctrl #(
    parameter int NREGS = 61,
    parameter int IDX_W = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [7:0]       wr_data,
    input  logic             frame_done,
    input  logic             vsync,
    input  logic             render_busy,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [7:0]       rd_data,
    output logic             pending,
    output logic             swap_pulse,
    output logic             render_start,
    output logic             bank_sel,
`ifdef PARAM_CHECKSUM_EN
    output logic [CNT_W-1:0] cks_err_cnt,
`endif
    output logic [CNT_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {S_FILL, S_PENDING, S_SWAP, S_START} state_t;

    localparam logic [IDX_W:0] LIM = (IDX_W+1)'(NREGS);

    state_t           state;
    logic [7:0]       bank0 [NREGS];
    logic [7:0]       bank1 [NREGS];
    logic [NREGS-1:0] mask;
    logic [NREGS-1:0] wr_bit;
    logic [NREGS-1:0] mask_w;
    logic             wr_ok;
    logic             wr_store;

`ifdef PARAM_CHECKSUM_EN
    localparam logic [IDX_W:0] LIM_CK = (IDX_W+1)'(NREGS-1);
    logic [7:0] sum;
    logic [7:0] sum_w;
    logic [7:0] cks_byte;
    logic       cks_ok;
`endif

    // Decode the incoming byte: legal index, whether this state stores it, and the updated mask
    always_comb begin
        wr_ok    = wr_en && ({1'b0, wr_idx} < LIM);
        wr_store = wr_ok && ((state == S_FILL) || (state == S_START) ||
                             ((state == S_PENDING) && (wr_idx == '0)));
        wr_bit   = wr_ok ? (NREGS'(1) << wr_idx) : '0;
        mask_w   = mask | wr_bit;
    end

`ifdef PARAM_CHECKSUM_EN
    // Running sum includes this cycle's byte; checksum byte may arrive alongside frame_done
    always_comb begin
        sum_w    = sum + ((wr_store && ({1'b0, wr_idx} < LIM_CK)) ? wr_data : 8'd0);
        cks_byte = (wr_store && ({1'b0, wr_idx} == LIM_CK)) ? wr_data
                 : (bank_sel ? bank0[NREGS-1] : bank1[NREGS-1]);
        cks_ok   = (sum_w == cks_byte);
    end
`endif

    // Active-bank read port, zero outside the parameter range
    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_idx} < LIM)
            rd_data = bank_sel ? bank1[rd_idx] : bank0[rd_idx];
    end

    // Shadow bank storage; the active bank is never written
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                bank0[i] <= '0;
                bank1[i] <= '0;
            end
        end else if (wr_store) begin
            if (bank_sel)
                bank0[wr_idx] <= wr_data;
            else
                bank1[wr_idx] <= wr_data;
        end
    end

    // Frame scheduler FSM with registered status pulses and saturating counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_FILL;
            mask         <= '0;
            bank_sel     <= 1'b0;
            pending      <= 1'b0;
            swap_pulse   <= 1'b0;
            render_start <= 1'b0;
            drop_cnt     <= '0;
`ifdef PARAM_CHECKSUM_EN
            sum          <= '0;
            cks_err_cnt  <= '0;
`endif
        end else begin
            swap_pulse   <= 1'b0;
            render_start <= 1'b0;
            case (state)
                S_FILL: begin
                    if (frame_done) begin
                        if (&mask_w) begin
`ifdef PARAM_CHECKSUM_EN
                            if (cks_ok) begin
                                state   <= S_PENDING;
                                pending <= 1'b1;
                                mask    <= mask_w;
                                sum     <= sum_w;
                            end else begin
                                mask <= '0;
                                sum  <= '0;
                                if (cks_err_cnt != '1)
                                    cks_err_cnt <= cks_err_cnt + 1'b1;
                            end
`else
                            state   <= S_PENDING;
                            pending <= 1'b1;
                            mask    <= mask_w;
`endif
                        end else begin
                            mask <= '0;
`ifdef PARAM_CHECKSUM_EN
                            sum  <= '0;
`endif
                            if (drop_cnt != '1)
                                drop_cnt <= drop_cnt + 1'b1;
                        end
                    end else begin
                        mask <= mask_w;
`ifdef PARAM_CHECKSUM_EN
                        sum  <= sum_w;
`endif
                    end
                end
                S_PENDING: begin
                    // A new byte 0 starts a fresh frame and wins over a coincident vsync
                    if (wr_store) begin
                        state   <= S_FILL;
                        pending <= 1'b0;
                        mask    <= wr_bit;
`ifdef PARAM_CHECKSUM_EN
                        sum     <= wr_data;
`endif
                        if (drop_cnt != '1)
                            drop_cnt <= drop_cnt + 1'b1;
                    end else if (vsync && !render_busy) begin
                        state      <= S_SWAP;
                        bank_sel   <= ~bank_sel;
                        swap_pulse <= 1'b1;
                        pending    <= 1'b0;
                        mask       <= '0;
`ifdef PARAM_CHECKSUM_EN
                        sum        <= '0;
`endif
                    end
                end
                S_SWAP: begin
                    state        <= S_START;
                    render_start <= 1'b1;
                end
                S_START: begin
                    state <= S_FILL;
                    mask  <= mask_w;
`ifdef PARAM_CHECKSUM_EN
                    sum   <= sum_w;
`endif
                end
                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_param_bank_ctrl.sv
// Directed self-checking bench for param_bank_ctrl (NREGS=61, IDX_W=6, CNT_W=8).
module tb_param_bank_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [5:0] wr_idx;
    logic [7:0] wr_data;
    logic       frame_done;
    logic       vsync;
    logic       render_busy;
    logic [5:0] rd_idx;
    logic [7:0] rd_data;
    logic       pending;
    logic       swap_pulse;
    logic       render_start;
    logic       bank_sel;
    logic [7:0] drop_cnt;
`ifdef PARAM_CHECKSUM_EN
    logic [7:0] cks_err_cnt;
`endif

    int total = 0;
    int bad   = 0;

    param_bank_ctrl #(.NREGS(61), .IDX_W(6), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_idx       (wr_idx),
        .wr_data      (wr_data),
        .frame_done   (frame_done),
        .vsync        (vsync),
        .render_busy  (render_busy),
        .rd_idx       (rd_idx),
        .rd_data      (rd_data),
        .pending      (pending),
        .swap_pulse   (swap_pulse),
        .render_start (render_start),
        .bank_sel     (bank_sel),
`ifdef PARAM_CHECKSUM_EN
        .cks_err_cnt  (cks_err_cnt),
`endif
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int idx, input int data);
        wr_en   = 1'b1;
        wr_idx  = 6'(idx);
        wr_data = 8'(data);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_fd();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    task automatic pulse_vs();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int idx, input int exp);
        rd_idx = 6'(idx);
        #1;
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_data = '0;
        frame_done = 1'b0; vsync = 1'b0; render_busy = 1'b0; rd_idx = 6'd5;
        do_reset();

        // Reset state
        rd_chk("rst_rd5", 5, 0);
        chk("rst_bank_sel", 32'(bank_sel), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_swap", 32'(swap_pulse), 0);
        chk("rst_start", 32'(render_start), 0);

`ifndef PARAM_CHECKSUM_EN
        // Full frame idx+1, swap on idle vsync
        for (int i = 0; i < 61; i++) wr(i, i + 1);
        pulse_fd();
        chk("f1_pending", 32'(pending), 1);
        rd_chk("f1_rd_old_active", 5, 0);
        pulse_vs();
        chk("f1_swap", 32'(swap_pulse), 1);
        chk("f1_bank_sel", 32'(bank_sel), 1);
        chk("f1_start_early", 32'(render_start), 0);
        chk("f1_pending_clr", 32'(pending), 0);
        tick();
        chk("f1_start", 32'(render_start), 1);
        chk("f1_swap_end", 32'(swap_pulse), 0);
        rd_chk("f1_rd60", 60, 61);
        rd_chk("f1_rd0", 0, 1);
        rd_chk("f1_rd61_oob", 61, 0);
        rd_chk("f1_rd63_oob", 63, 0);
        tick();

        // Incomplete frame (0..59, plus out-of-range indices) is dropped
        for (int i = 0; i < 60; i++) wr(i, 8'h10);
        wr(61, 8'hEE);
        wr(63, 8'hEE);
        pulse_fd();
        chk("inc_drop", 32'(drop_cnt), 1);
        chk("inc_pending", 32'(pending), 0);
        pulse_vs();
        chk("inc_no_swap", 32'(swap_pulse), 0);
        chk("inc_bank_sel", 32'(bank_sel), 1);
        tick();
        chk("inc_no_start", 32'(render_start), 0);
        rd_chk("inc_rd60", 60, 61);

        // Last byte coincides with frame_done; busy renderer defers swap
        for (int i = 0; i < 60; i++) wr(i, 2 * i);
        wr_en = 1'b1; wr_idx = 6'd60; wr_data = 8'h77; frame_done = 1'b1;
        tick();
        wr_en = 1'b0; frame_done = 1'b0;
        chk("co_pending", 32'(pending), 1);
        chk("co_drop", 32'(drop_cnt), 1);
        pulse_fd();
        chk("pend_fd_ignored_p", 32'(pending), 1);
        chk("pend_fd_ignored_d", 32'(drop_cnt), 1);
        render_busy = 1'b1;
        pulse_vs();
        chk("busy_no_swap", 32'(swap_pulse), 0);
        chk("busy_pending", 32'(pending), 1);
        chk("busy_bank_sel", 32'(bank_sel), 1);
        rd_chk("busy_rd60", 60, 61);
        tick();
        render_busy = 1'b0;
        pulse_vs();
        chk("idle_swap", 32'(swap_pulse), 1);
        chk("idle_bank_sel", 32'(bank_sel), 0);
        tick();
        chk("idle_start", 32'(render_start), 1);
        rd_chk("idle_rd60", 60, 8'h77);
        rd_chk("idle_rd10", 10, 20);
        tick();

        // Pending frame superseded by a new byte 0
        for (int i = 0; i < 61; i++) wr(i, 8'h55);
        pulse_fd();
        chk("sup_pending", 32'(pending), 1);
        wr(5, 8'h99);
        chk("sup_ign_pending", 32'(pending), 1);
        chk("sup_ign_drop", 32'(drop_cnt), 1);
        wr(0, 8'hAA);
        chk("sup_drop", 32'(drop_cnt), 2);
        chk("sup_pending_clr", 32'(pending), 0);
        rd_chk("sup_rd60", 60, 8'h77);
        pulse_vs();
        chk("sup_fill_no_swap", 32'(swap_pulse), 0);
        for (int i = 1; i < 61; i++) wr(i, 8'h66);
        pulse_fd();
        chk("sup2_pending", 32'(pending), 1);
        chk("sup2_drop", 32'(drop_cnt), 2);
        pulse_vs();
        chk("sup2_swap", 32'(swap_pulse), 1);
        chk("sup2_bank_sel", 32'(bank_sel), 1);
        tick();
        rd_chk("sup2_rd0", 0, 8'hAA);
        rd_chk("sup2_rd30", 30, 8'h66);
        tick();

        // Reset in the middle of a swap discards everything
        for (int i = 0; i < 61; i++) wr(i, 8'h33);
        pulse_fd();
        pulse_vs();
        chk("ms_swap", 32'(swap_pulse), 1);
        chk("ms_bank_sel", 32'(bank_sel), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("ms_swap_clr", 32'(swap_pulse), 0);
        chk("ms_start_clr", 32'(render_start), 0);
        chk("ms_bank_sel_rst", 32'(bank_sel), 0);
        chk("ms_drop_rst", 32'(drop_cnt), 0);
        rd_chk("ms_rd30", 30, 0);
        tick();
        chk("ms_no_start", 32'(render_start), 0);

        // Drop counter saturates
        for (int i = 0; i < 260; i++) pulse_fd();
        chk("sat_drop", 32'(drop_cnt), 8'hFF);
`else
        // Checksum accepted: bytes 0..59 = 1, byte 60 = 60
        for (int i = 0; i < 60; i++) wr(i, 1);
        wr(60, 8'h3C);
        pulse_fd();
        chk("ck_ok_pending", 32'(pending), 1);
        chk("ck_ok_err", 32'(cks_err_cnt), 0);
        pulse_vs();
        chk("ck_ok_swap", 32'(swap_pulse), 1);
        chk("ck_ok_bank_sel", 32'(bank_sel), 1);
        tick();
        chk("ck_ok_start", 32'(render_start), 1);
        rd_chk("ck_ok_rd60", 60, 8'h3C);
        tick();

        // Checksum mismatch: counted, no swap
        for (int i = 0; i < 60; i++) wr(i, 1);
        wr(60, 8'h3D);
        pulse_fd();
        chk("ck_bad_pending", 32'(pending), 0);
        chk("ck_bad_err", 32'(cks_err_cnt), 1);
        chk("ck_bad_drop", 32'(drop_cnt), 0);
        pulse_vs();
        chk("ck_bad_no_swap", 32'(swap_pulse), 0);
        chk("ck_bad_bank_sel", 32'(bank_sel), 1);
        rd_chk("ck_bad_rd60", 60, 8'h3C);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
